// File: rtl/v_lsu_bank_ctrl.sv
// Vector LSU bank controller: one unit-stride or word-strided request at a time over four memory banks.
// Group/element n issues in cycle n+1 and its load data reaches the VRF a cycle later; issue never stalls, req_ready only in IDLE.
module v_lsu_bank_ctrl #(
    parameter int ADDR_BITS = 14,
    parameter int DATA_W    = 32,
    parameter int MAX_VL    = 32
) (
    input  logic                          core_clk,
    input  logic                          nrst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_store,
    input  logic                          req_strided,
    input  logic [ADDR_BITS-1:0]          req_base,
    input  logic [ADDR_BITS-1:0]          req_stride,
    input  logic [$clog2(MAX_VL+1)-1:0]   req_vl,
    output logic                          busy,
    output logic                          done,
    output logic [3:0]                    dm_write_0,
    output logic [3:0]                    dm_write_1,
    output logic [3:0]                    dm_write_2,
    output logic [3:0]                    dm_write_3,
    output logic [ADDR_BITS-1:0]          data_addr0,
    output logic [ADDR_BITS-1:0]          data_addr1,
    output logic [ADDR_BITS-1:0]          data_addr2,
    output logic [ADDR_BITS-1:0]          data_addr3,
    output logic [DATA_W-1:0]             data_in_0,
    output logic [DATA_W-1:0]             data_in_1,
    output logic [DATA_W-1:0]             data_in_2,
    output logic [DATA_W-1:0]             data_in_3,
    input  logic [DATA_W-1:0]             data_out_0,
    input  logic [DATA_W-1:0]             data_out_1,
    input  logic [DATA_W-1:0]             data_out_2,
    input  logic [DATA_W-1:0]             data_out_3,
    output logic [$clog2(MAX_VL/4)-1:0]   st_grp,
    input  logic [4*DATA_W-1:0]           st_data,
    output logic                          vrf_we,
    output logic [$clog2(MAX_VL/4)-1:0]   vrf_grp,
    output logic [3:0]                    vrf_wmask,
    output logic [4*DATA_W-1:0]           vrf_wdata
);

    localparam int AW  = ADDR_BITS - 1;
    localparam int VLW = $clog2(MAX_VL + 1);
    localparam int GW  = $clog2(MAX_VL / 4);
    localparam int CW  = VLW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    function automatic logic [DATA_W-1:0] bswap(input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < DATA_W / 8; i++) r[8*i +: 8] = w[DATA_W-8-8*i +: 8];
        return r;
    endfunction

    state_t              state;
    logic                r_store;
    logic                r_strided;
    logic [AW-1:0]       r_stride;
    logic [AW-1:0]       cur;
    logic [VLW-1:0]      r_vl;
    logic [VLW-1:0]      k0;
    logic                rd_vld;
    logic [GW-1:0]       rd_grp;
    logic [3:0]          rd_mask;
    logic [1:0]          rd_sel [4];

    logic                issuing;
    logic                last;
    logic [GW-1:0]       grp;
    logic [3:0]          lane_mask;
    logic [1:0]          lane_sel [4];
    logic [AW-1:0]       lane_addr [4];
    logic [ADDR_BITS-1:0] bank_addr [4];
    logic [3:0]          bank_we [4];
    logic [DATA_W-1:0]   bank_din [4];
    logic [DATA_W-1:0]   bank_dout [4];
    logic                unused_region;

    // The protocol-region bit is never generated, so the request MSBs are dropped.
    assign unused_region = req_base[ADDR_BITS-1] ^ req_stride[ADDR_BITS-1];

    assign bank_dout[0] = data_out_0;
    assign bank_dout[1] = data_out_1;
    assign bank_dout[2] = data_out_2;
    assign bank_dout[3] = data_out_3;

    assign last = r_strided ? (CW'(k0) + CW'(1) >= CW'(r_vl))
                            : (CW'(k0) + CW'(4) >= CW'(r_vl));

    always_comb begin
        issuing   = nrst && (state == S_ISSUE);
        grp       = k0[GW+1:2];
        lane_mask = '0;
        for (int j = 0; j < 4; j++) begin
            lane_sel[j]  = 2'd0;
            lane_addr[j] = cur + AW'(j);
            bank_addr[j] = '0;
            bank_we[j]   = '0;
            bank_din[j]  = '0;
        end
        if (issuing) begin
            if (r_strided) begin
                lane_mask[k0[1:0]]    = 1'b1;
                lane_sel[k0[1:0]]     = cur[1:0];
                bank_addr[cur[1:0]]   = {1'b0, cur};
                if (r_store) begin
                    bank_we[cur[1:0]]  = 4'hF;
                    bank_din[cur[1:0]] = st_data[DATA_W*int'(k0[1:0]) +: DATA_W];
                end
            end else begin
                // Lane j of the group lands on bank (base+j) mod 4; every bank carries its row.
                for (int j = 0; j < 4; j++) begin
                    lane_mask[j]                   = (CW'(k0) + CW'(j)) < CW'(r_vl);
                    lane_sel[j]                    = lane_addr[j][1:0];
                    bank_addr[lane_addr[j][1:0]]   = {1'b0, lane_addr[j]};
                    if (r_store && lane_mask[j]) begin
                        bank_we[lane_addr[j][1:0]]  = 4'hF;
                        bank_din[lane_addr[j][1:0]] = st_data[DATA_W*j +: DATA_W];
                    end
                end
            end
        end
    end

    always_ff @(posedge core_clk) begin
        if (!nrst) begin
            state     <= S_IDLE;
            r_store   <= 1'b0;
            r_strided <= 1'b0;
            r_stride  <= '0;
            r_vl      <= '0;
            cur       <= '0;
            k0        <= '0;
            rd_vld    <= 1'b0;
            rd_grp    <= '0;
            rd_mask   <= '0;
            rd_sel    <= '{default: 2'd0};
        end else begin
            rd_vld  <= issuing && !r_store;
            rd_grp  <= grp;
            rd_mask <= lane_mask;
            rd_sel  <= lane_sel;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_store   <= req_store;
                        r_strided <= req_strided;
                        r_stride  <= req_stride[AW-1:0];
                        r_vl      <= req_vl;
                        cur       <= req_base[AW-1:0];
                        k0        <= '0;
                        state     <= (req_vl == '0) ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cur <= cur + (r_strided ? r_stride : AW'(4));
                    k0  <= k0 + (r_strided ? VLW'(1) : VLW'(4));
                    if (last) state <= r_store ? S_DONE : S_DRAIN;
                end
                S_DRAIN: state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    assign dm_write_0 = bank_we[0];
    assign dm_write_1 = bank_we[1];
    assign dm_write_2 = bank_we[2];
    assign dm_write_3 = bank_we[3];
    assign data_addr0 = bank_addr[0];
    assign data_addr1 = bank_addr[1];
    assign data_addr2 = bank_addr[2];
    assign data_addr3 = bank_addr[3];
    assign data_in_0  = bank_din[0];
    assign data_in_1  = bank_din[1];
    assign data_in_2  = bank_din[2];
    assign data_in_3  = bank_din[3];

    assign st_grp    = (issuing && r_store) ? grp : '0;
    assign vrf_we    = nrst && rd_vld;
    assign vrf_grp   = vrf_we ? rd_grp : '0;
    assign vrf_wmask = vrf_we ? rd_mask : '0;

    // Banks return little-endian words; the VRF holds them big-endian.
    always_comb begin
        vrf_wdata = '0;
        for (int j = 0; j < 4; j++) begin
            if (vrf_we && rd_mask[j]) vrf_wdata[DATA_W*j +: DATA_W] = bswap(bank_dout[rd_sel[j]]);
        end
    end

endmodule

// File: tb/tb_v_lsu_bank_ctrl.sv
// Directed bench for v_lsu_bank_ctrl: banked memory model, VRF capture, vector table plus corner sequences.
module tb_v_lsu_bank_ctrl;

    logic         core_clk;
    logic         nrst;
    logic         req_valid, req_ready, req_store, req_strided;
    logic [13:0]  req_base, req_stride;
    logic [5:0]   req_vl;
    logic         busy, done;
    logic [3:0]   dm_write_0, dm_write_1, dm_write_2, dm_write_3;
    logic [13:0]  data_addr0, data_addr1, data_addr2, data_addr3;
    logic [31:0]  data_in_0, data_in_1, data_in_2, data_in_3;
    logic [2:0]   st_grp;
    logic [127:0] st_data;
    logic         vrf_we;
    logic [2:0]   vrf_grp;
    logic [3:0]   vrf_wmask;
    logic [127:0] vrf_wdata;

    logic [31:0]  mem [4][2048];
    logic [31:0]  dout_q [4];
    logic [127:0] src_mem [8];
    logic [31:0]  vrf_img [8][4];
    logic [3:0]   dmw [4];
    logic [13:0]  daddr [4];
    logic [31:0]  din [4];
    int           checks = 0;
    int           failures = 0;
    int           bw_cnt = 0;

    typedef struct {
        logic        store;
        logic        strided;
        logic [13:0] base;
        logic [13:0] stride;
        logic [5:0]  vl;
        int          exp_done;
        int          exp_vwe;
        int          exp_first;
        int          exp_bw;
    } vec_t;

    vec_t vecs [11];

    v_lsu_bank_ctrl dut (
        .core_clk(core_clk), .nrst(nrst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_strided(req_strided), .req_base(req_base), .req_stride(req_stride),
        .req_vl(req_vl), .busy(busy), .done(done),
        .dm_write_0(dm_write_0), .dm_write_1(dm_write_1),
        .dm_write_2(dm_write_2), .dm_write_3(dm_write_3),
        .data_addr0(data_addr0), .data_addr1(data_addr1),
        .data_addr2(data_addr2), .data_addr3(data_addr3),
        .data_in_0(data_in_0), .data_in_1(data_in_1),
        .data_in_2(data_in_2), .data_in_3(data_in_3),
        .data_out_0(dout_q[0]), .data_out_1(dout_q[1]),
        .data_out_2(dout_q[2]), .data_out_3(dout_q[3]),
        .st_grp(st_grp), .st_data(st_data),
        .vrf_we(vrf_we), .vrf_grp(vrf_grp), .vrf_wmask(vrf_wmask), .vrf_wdata(vrf_wdata)
    );

    assign dmw[0] = dm_write_0;  assign dmw[1] = dm_write_1;
    assign dmw[2] = dm_write_2;  assign dmw[3] = dm_write_3;
    assign daddr[0] = data_addr0; assign daddr[1] = data_addr1;
    assign daddr[2] = data_addr2; assign daddr[3] = data_addr3;
    assign din[0] = data_in_0;   assign din[1] = data_in_1;
    assign din[2] = data_in_2;   assign din[3] = data_in_3;
    assign st_data = src_mem[st_grp];

    initial begin
        core_clk = 1'b0;
        forever #5 core_clk = ~core_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int a);
        return {3'b101, 13'(a), 16'(a * 5) ^ 16'h5AC3};
    endfunction

    function automatic logic [31:0] bs(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [31:0] mrd(input int a);
        return mem[a & 3][(a >> 2) & 2047];
    endfunction

    function automatic logic [31:0] el(input int k);
        logic [127:0] g;
        g = src_mem[k / 4];
        return g[32*(k % 4) +: 32];
    endfunction

    function automatic int addr_of(input vec_t v, input int k);
        if (v.strided) return (int'(v.base) + k * int'(v.stride)) & 32'h1FFF;
        return (int'(v.base) + k) & 32'h1FFF;
    endfunction

    // One-cycle latency read port of the banked memory.
    always @(posedge core_clk) begin
        for (int b = 0; b < 4; b++) dout_q[b] <= mem[b][daddr[b][12:2]];
    end

    always @(negedge core_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (dmw[b] !== 4'h0) begin
                bw_cnt++;
                check("bank_wr", {dmw[b], daddr[b][13], daddr[b][1:0]}, {4'hF, 1'b0, 2'(b)});
                mem[b][daddr[b][12:2]] = din[b];
            end
        end
        if (vrf_we === 1'b1) begin
            for (int j = 0; j < 4; j++)
                if (vrf_wmask[j]) vrf_img[vrf_grp][j] = vrf_wdata[32*j +: 32];
        end
    end

    task automatic step();
        @(negedge core_clk);
        #1;
    endtask

    task automatic issue(input logic st, input logic sd, input logic [13:0] b,
                         input logic [13:0] s, input logic [5:0] vl);
        req_store = st; req_strided = sd; req_base = b; req_stride = s; req_vl = vl;
        req_valid = 1'b1;
        check("req_ready_idle", req_ready, 1'b1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic finish_req();
        for (int i = 0; i < 60 && busy; i++) step();
        check("idle_after", busy, 1'b0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int done_cyc, first_we, npulse, bw0, ngrp;
        for (int g = 0; g < 8; g++)
            for (int j = 0; j < 4; j++) vrf_img[g][j] = 32'hDEADBEEF;
        bw0 = bw_cnt; done_cyc = -1; first_we = -1; npulse = 0;
        issue(v.store, v.strided, v.base, v.stride, v.vl);
        for (int c = 1; c <= 60; c++) begin
            if (vrf_we) begin
                if (first_we < 0) first_we = c;
                check($sformatf("v%0d_grp", idx), vrf_grp, v.strided ? npulse / 4 : npulse);
                npulse++;
            end
            if (done) begin
                done_cyc = c;
                check($sformatf("v%0d_busy_at_done", idx), {busy, req_ready}, 2'b10);
                break;
            end
            step();
        end
        check($sformatf("v%0d_done_cycle", idx), done_cyc, v.exp_done);
        check($sformatf("v%0d_vrf_we_count", idx), npulse, v.exp_vwe);
        check($sformatf("v%0d_first_we", idx), first_we, v.exp_first);
        step();
        check($sformatf("v%0d_idle", idx), {req_ready, busy, done}, 3'b100);
        check($sformatf("v%0d_bank_writes", idx), bw_cnt - bw0, v.exp_bw);
        ngrp = (int'(v.vl) + 3) / 4;
        for (int k = 0; k < ngrp * 4; k++) begin
            if (k < int'(v.vl)) begin
                if (v.store) check($sformatf("v%0d_st_el%0d", idx, k), mrd(addr_of(v, k)), el(k));
                else check($sformatf("v%0d_ld_el%0d", idx, k), vrf_img[k/4][k%4], bs(mrd(addr_of(v, k))));
            end else if (!v.store) begin
                check($sformatf("v%0d_masked_el%0d", idx, k), vrf_img[k/4][k%4], 32'hDEADBEEF);
            end
        end
    endtask

    initial begin
        for (int b = 0; b < 4; b++)
            for (int r = 0; r < 2048; r++) mem[b][r] = pat(r * 4 + b);
        for (int k = 0; k < 32; k++)
            src_mem[k/4][32*(k%4) +: 32] = {8'(k * 17), 8'h5A, 16'(k * 37 + 1)};
        for (int b = 0; b < 4; b++) dout_q[b] = '0;

        //             st    sd    base      stride    vl     done vwe first bw
        vecs[0]  = '{1'b0, 1'b0, 14'h0000, 14'h0000, 6'd32, 10,  8,  2,  0};
        vecs[1]  = '{1'b0, 1'b0, 14'h0003, 14'h0000, 6'd5,  4,   2,  2,  0};
        vecs[2]  = '{1'b1, 1'b0, 14'h1FFE, 14'h0000, 6'd4,  2,   0, -1,  4};
        vecs[3]  = '{1'b0, 1'b1, 14'h0010, 14'h3FFD, 6'd3,  5,   3,  2,  0};
        vecs[4]  = '{1'b0, 1'b0, 14'h0040, 14'h0000, 6'd0,  1,   0, -1,  0};
        vecs[5]  = '{1'b1, 1'b1, 14'h1FFD, 14'h0007, 6'd6,  7,   0, -1,  6};
        vecs[6]  = '{1'b1, 1'b0, 14'h0101, 14'h0000, 6'd9,  4,   0, -1,  9};
        vecs[7]  = '{1'b0, 1'b1, 14'h0022, 14'h0000, 6'd4,  6,   4,  2,  0};
        vecs[8]  = '{1'b0, 1'b0, 14'h1FFC, 14'h0000, 6'd7,  4,   2,  2,  0};
        vecs[9]  = '{1'b0, 1'b0, 14'h0101, 14'h0000, 6'd9,  5,   3,  2,  0};
        vecs[10] = '{1'b0, 1'b1, 14'h1FFD, 14'h0007, 6'd6,  8,   6,  2,  0};

        nrst = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_strided = 1'b0;
        req_base = '0; req_stride = '0; req_vl = '0;
        step(); step();
        check("reset_ctrl", {req_ready, busy, done, vrf_we, vrf_wmask, st_grp,
                             dmw[0], dmw[1], dmw[2], dmw[3]}, {1'b1, 26'b0});
        check("reset_addr", {daddr[0], daddr[1], daddr[2], daddr[3]}, 56'b0);
        nrst = 1'b1;
        step();

        // Unit load from misaligned base: bank 3 leads, banks 0-2 one row up.
        issue(1'b0, 1'b0, 14'h0003, 14'h0000, 6'd5);
        check("ul_g0_addr", {daddr[0], daddr[1], daddr[2], daddr[3]}, {14'h4, 14'h5, 14'h6, 14'h3});
        check("ul_g0_nowrite", {dmw[0], dmw[1], dmw[2], dmw[3]}, 16'h0);
        step();
        check("ul_g1_addr", {daddr[0], daddr[1], daddr[2], daddr[3]}, {14'h8, 14'h9, 14'hA, 14'h7});
        check("ul_g0_vrf", {vrf_we, vrf_grp, vrf_wmask}, {1'b1, 3'd0, 4'hF});
        check("ul_g0_data", vrf_wdata, {bs(mrd(6)), bs(mrd(5)), bs(mrd(4)), bs(mrd(3))});
        step();
        check("ul_g1_vrf", {vrf_we, vrf_grp, vrf_wmask}, {1'b1, 3'd1, 4'b0001});
        finish_req();
        step();

        // Unit store straddling the top of the core region.
        issue(1'b1, 1'b0, 14'h1FFE, 14'h0000, 6'd4);
        check("us_addr", {daddr[0], daddr[1], daddr[2], daddr[3]}, {14'h0, 14'h1, 14'h1FFE, 14'h1FFF});
        check("us_we", {dmw[0], dmw[1], dmw[2], dmw[3], st_grp}, {16'hFFFF, 3'd0});
        check("us_data", {din[0], din[1], din[2], din[3]}, {el(2), el(3), el(0), el(1)});
        step();
        check("us_done", {done, busy}, 2'b11);
        finish_req();
        step();

        // Strided load with negative stride.
        issue(1'b0, 1'b1, 14'h0010, 14'h3FFD, 6'd3);
        check("sl_e0_addr", {daddr[0], daddr[1], daddr[2], daddr[3]}, {14'h10, 14'h0, 14'h0, 14'h0});
        step();
        check("sl_e1_addr", {daddr[0], daddr[1], daddr[2], daddr[3]}, {14'h0, 14'hD, 14'h0, 14'h0});
        check("sl_e0_vrf", {vrf_we, vrf_grp, vrf_wmask}, {1'b1, 3'd0, 4'b0001});
        check("sl_e0_data", vrf_wdata, {96'b0, bs(mrd(16'h10))});
        step();
        check("sl_e2_addr", {daddr[0], daddr[1], daddr[2], daddr[3]}, {14'h0, 14'h0, 14'hA, 14'h0});
        check("sl_e1_vrf", {vrf_we, vrf_wmask}, {1'b1, 4'b0010});
        check("sl_e1_data", vrf_wdata, {64'b0, bs(mrd(16'hD)), 32'b0});
        step();
        check("sl_drain", {vrf_we, vrf_grp, vrf_wmask, busy, done}, {1'b1, 3'd0, 4'b0100, 1'b1, 1'b0});
        check("sl_e2_data", vrf_wdata, {32'b0, bs(mrd(16'hA)), 64'b0});
        step();
        check("sl_done", done, 1'b1);
        finish_req();
        step();

        // Reset in the middle of a long store.
        begin
            int bw_mark;
            issue(1'b1, 1'b0, 14'h0000, 14'h0000, 6'd32);
            step(); step(); step();
            check("rst_mid_active", {dmw[0], st_grp}, {4'hF, 3'd3});
            nrst = 1'b0;
            #1;
            check("rst_gate", {dmw[0], dmw[1], dmw[2], dmw[3], vrf_we}, 17'b0);
            bw_mark = bw_cnt;
            step();
            check("rst_state", {req_ready, busy, done}, 3'b100);
            nrst = 1'b1;
            step(); step(); step();
            check("rst_no_writes", bw_cnt - bw_mark, 0);
        end

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
